// File: rtl/uart_serdes.sv
// uart_serdes: full-duplex UART serialiser/deserialiser in a single clock domain.
// Optional UART_PARITY_EN adds one even-parity bit per frame on both TX and RX.
module uart_serdes #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 internal_clk,
  input  logic                 internal_rst_n,
  input  logic [WORD_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_bit,
  input  logic                 rx_bit,
  output logic [WORD_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  // state     | meaning
  // IDLE      | TX: waiting for a word; RX: waiting for the line to go low
  // START     | start bit (RX: checked at mid-bit, glitches abort)
  // DATA      | data bits, LSB first
  // PARITY    | even parity bit (UART_PARITY_EN builds only)
  // STOP      | stop bit(s); RX reports the word at the first stop sample
  // WAIT_HIGH | RX only: line must return high before a new frame
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_MID     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST   = IW'(WORD_SIZE - 1);
  localparam logic [IW-1:0] STOP_LAST   = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [WORD_SIZE-1:0] tx_shift;
  logic                 tx_accept;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_accept = tx_valid & tx_ready;

  always_ff @(posedge internal_clk or negedge internal_rst_n) begin
    if (!internal_rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_bit   <= 1'b1;
      tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_accept) begin
      tx_state <= S_START;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= tx_data;
      tx_bit   <= 1'b0;
      tx_ready <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= ^tx_data;
`endif
    end else if (tx_state != S_IDLE) begin
      tx_cnt <= (tx_cnt == BIT_LAST) ? '0 : tx_cnt + 1'b1;
      if (tx_cnt == BIT_LAST) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bit   <= tx_shift[0];
          end
          S_DATA: begin
            if (tx_idx == DATA_LAST) begin
              tx_idx   <= '0;
`ifdef UART_PARITY_EN
              tx_state <= S_PARITY;
              tx_bit   <= tx_par;
`else
              tx_state <= S_STOP;
              tx_bit   <= 1'b1;
`endif
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_shift[1];
            end
          end
          S_PARITY: begin
            tx_state <= S_STOP;
            tx_bit   <= 1'b1;
          end
          S_STOP: begin
            if (tx_idx == STOP_LAST) tx_state <= S_IDLE;
            else                     tx_idx   <= tx_idx + 1'b1;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
      // Raise ready one cycle early so an accept lands exactly on the frame boundary
      if (tx_state == S_STOP && tx_idx == STOP_LAST && tx_cnt == BIT_PRELAST)
        tx_ready <= 1'b1;
    end
  end

  logic                 rx_s1, rx_s2;
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [WORD_SIZE-1:0] rx_shift;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad;
`else
  assign rx_parity_err = 1'b0;
`endif

  // Synchroniser resets high so reset release never looks like a start bit
  always_ff @(posedge internal_clk or negedge internal_rst_n) begin
    if (!internal_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_bit;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge internal_clk or negedge internal_rst_n) begin
    if (!internal_rst_n) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == BIT_MID) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[WORD_SIZE-1:1]};
            if (rx_idx == DATA_LAST) begin
              rx_idx <= '0;
`ifdef UART_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end else rx_idx <= rx_idx + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_STOP;
`ifdef UART_PARITY_EN
            rx_par_bad <= rx_s2 ^ (^rx_shift);
`endif
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt       <= '0;
            rx_data      <= rx_shift;
            rx_frame_err <= ~rx_s2;
            rx_valid     <= 1'b1;
            rx_state     <= S_WAIT_HIGH;
`ifdef UART_PARITY_EN
            rx_parity_err <= rx_par_bad;
`endif
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        S_WAIT_HIGH: if (rx_s2) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule
